// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin Mealy arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_N_REQ    = 4;
    localparam int unsigned DEF_MAX_HOLD = 8;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Wrap-around first-set search starting at ptr_i, skipping bits in excl_i.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  excl_i,
    output logic          found_o,
    output logic [IW-1:0] index_o
);

    logic [N-1:0] cand;

    always_comb begin
        cand    = req_i & ~excl_i;
        found_o = 1'b0;
        index_o = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_o && cand[(int'(ptr_i) + k) % N]) begin
                found_o = 1'b1;
                index_o = IW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/rr_mealy_arbiter.sv
// Round-robin Mealy arbiter with per-owner hold limit.
// Define RR_ARB_GRANT_REG_EN to register the grant outputs (one-cycle latency).
module rr_mealy_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int IW = int'(idx_w(N_REQ));
    localparam int HW = int'(cnt_w(MAX_HOLD));
    localparam logic [HW-1:0] MAXH = HW'(MAX_HOLD);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic [N_REQ-1:0] excl;
    logic             found;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    ptr_nxt;
    logic             take;

    logic [N_REQ-1:0] grant_c;
    logic [IW-1:0]    gid_c;

    // While the owner still requests, the search must look past it.
    always_comb begin
        excl = '0;
        if (state_q == BUSY && req[owner_q]) excl[owner_q] = 1'b1;
    end

    rr_priority_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .excl_i  (excl),
        .found_o (found),
        .index_o (pick_idx)
    );

    assign ptr_nxt = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_c = '0;
        gid_c   = '0;
        take    = 1'b0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (found) take = 1'b1;
                end
                BUSY: begin
                    if (req[owner_q]) begin
                        if (hold_q < MAXH) begin
                            grant_c[owner_q] = 1'b1;
                            gid_c            = owner_q;
                            hold_d           = hold_q + 1'b1;
                        end else if (found) begin
                            take = 1'b1;
                        end else begin
                            grant_c[owner_q] = 1'b1;
                            gid_c            = owner_q;
                            hold_d           = HW'(1);
                        end
                    end else if (found) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (take) begin
                grant_c[pick_idx] = 1'b1;
                gid_c             = pick_idx;
                state_d           = BUSY;
                owner_d           = pick_idx;
                ptr_d             = ptr_nxt;
                hold_d            = HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

`ifdef RR_ARB_GRANT_REG_EN
    logic [N_REQ-1:0] grant_q;
    logic             gvalid_q;
    logic [IW-1:0]    gid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q  <= '0;
            gvalid_q <= 1'b0;
            gid_q    <= '0;
        end else begin
            grant_q  <= grant_c;
            gvalid_q <= |grant_c;
            gid_q    <= gid_c;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = gvalid_q;
    assign grant_id    = gid_q;
`else
    assign grant       = grant_c;
    assign grant_valid = |grant_c;
    assign grant_id    = gid_c;
`endif

endmodule

// File: doc/rr_mealy_arbiter.md
RR_MEALY_ARBITER -- requirements
Module: rr_mealy_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter MAX_HOLD, default 8, maximum consecutive cycles one requester may hold the grant (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  N_REQ  request vector; bit i high = requester i wants the shared datapath.
REQ-006 SHALL have port grant  output  N_REQ  one-hot grant; all zero = no owner.
REQ-007 SHALL have port grant_valid  output  1  high when any grant bit is high.
REQ-008 SHALL have port grant_id  output  clog2(N_REQ)  index of the granted requester; 0 when grant_valid is low.

Function
REQ-009 SHALL be a Mealy FSM with states IDLE and BUSY; outputs are a function of state_reg, owner_reg, hold_cnt and req.
REQ-010 SHALL default each cycle to state_next = state_reg and outputs = 0 before case decoding.
REQ-011 SHALL, in IDLE with req == 0, drive grant = 0 and stay in IDLE.
REQ-012 SHALL, in IDLE with req != 0, grant the first set bit searching upward from ptr_reg with wrap, in the same cycle; next state BUSY, owner = that index, hold_cnt = 1, ptr = index+1 mod N_REQ.
REQ-013 SHALL, in BUSY with req[owner] high and hold_cnt < MAX_HOLD, keep granting owner and increment hold_cnt.
REQ-014 SHALL, in BUSY with req[owner] high and hold_cnt == MAX_HOLD, grant the first other requester from ptr with wrap; if no other requester is asserted, regrant owner with hold_cnt = 1.
REQ-015 SHALL, in BUSY with req[owner] low, grant the first set bit of req from ptr with wrap, in the same cycle; if req == 0, drive grant = 0 and go to IDLE.
REQ-016 SHALL update owner, ptr = new_index+1 mod N_REQ and hold_cnt = 1 on every handover to a different requester.
REQ-017 SHALL never assert more than one grant bit, nor grant a requester whose req bit is low in that cycle.
REQ-018 SHALL size hold_cnt as clog2(MAX_HOLD+1) bits with no wrap: saturate at MAX_HOLD.
REQ-019 SHALL guarantee that any continuously asserting requester is granted within (N_REQ-1)*MAX_HOLD+1 cycles.

Reset
REQ-020 SHALL, while reset is high, force grant = 0, grant_valid = 0 and grant_id = 0 regardless of req.
REQ-021 SHALL on a reset edge load state = IDLE, owner = 0, ptr = 0, hold_cnt = 0; reset mid-grant drops the grant in the same cycle.
REQ-022 SHALL make the first grant after reset release follow REQ-012 with ptr = 0.

Configuration
REQ-023 SHALL, with macro RR_ARB_GRANT_REG_EN defined, register grant, grant_valid and grant_id through glitch-removal D-FFs: one-cycle latency, registers reset to 0.
REQ-024 SHALL, without RR_ARB_GRANT_REG_EN, drive outputs combinationally from the Mealy logic with zero latency.

Structure
REQ-025 SHALL place the state encoding typedef (IDLE = 0, BUSY = 1) and the clog2 width constants in shared package arb_pkg.
REQ-026 SHALL implement the wrap-around search as combinational sub-module rr_priority_pick, with inputs req, ptr and exclude mask and outputs found and index.

Verification
REQ-027 SHALL cover idle-to-grant: reset then req = 4'b0100 -> grant = 4'b0100 in the same cycle, grant_id = 2, and ptr = 3 next cycle.
REQ-028 SHALL cover fair rotation: req = 4'b1111 held with MAX_HOLD = 2 -> grant sequence 0,0,1,1,2,2,3,3,0.
REQ-029 SHALL cover lone hog: only req[1] held for 20 cycles, MAX_HOLD = 8 -> grant stays 4'b0010 continuously, and hold_cnt restarts at 1 after 8 cycles.
REQ-030 SHALL cover release handover: owner 0 drops req while req = 4'b1010 and ptr = 1 -> grant = 4'b0010 in the same cycle; then all req drop -> grant = 0 and state = IDLE.
REQ-031 SHALL cover reset mid-grant: grant = 4'b1000 and reset asserted -> grant = 0 that cycle, and the first grant after release is from ptr = 0.
REQ-032 SHALL cover the registered build: with RR_ARB_GRANT_REG_EN defined, REQ-027 stimulus -> grant = 4'b0100 one cycle later, and zero glitches on grant.
